// File: rtl/peripheral_dbg_soc_osd_regaccess_router_if.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_soc_osd_regaccess_router_if
//
// Bundles the two buses around the register-access router:
//   reg_* : request side, driven by the OSD register-access layer
//   slv_* : bank side, fanning out to NSLV local register banks
//
// Modports:
//   slave  : the router's view (receives reg_* requests, drives slv_* requests)
//   master : the environment's view (requester plus banks), mirror of slave
// ---------------------------------------------------------------------------
interface peripheral_dbg_soc_osd_regaccess_router_if #(
    parameter int NSLV         = 2,
    parameter int MAX_REG_SIZE = 16
);
    // Requester side
    logic                         reg_request;
    logic                         reg_write;
    logic [15:0]                  reg_addr;
    logic [1:0]                   reg_size;
    logic [MAX_REG_SIZE-1:0]      reg_wdata;
    logic                         reg_ack;
    logic                         reg_err;
    logic [MAX_REG_SIZE-1:0]      reg_rdata;

    // Bank side
    logic [NSLV-1:0]              slv_request;
    logic                         slv_write;
    logic [15:0]                  slv_addr;
    logic [1:0]                   slv_size;
    logic [MAX_REG_SIZE-1:0]      slv_wdata;
    logic [NSLV-1:0]              slv_ack;
    logic [NSLV-1:0]              slv_err;
    logic [NSLV*MAX_REG_SIZE-1:0] slv_rdata;

    modport slave (
        input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        output reg_ack, reg_err, reg_rdata,
        output slv_request, slv_write, slv_addr, slv_size, slv_wdata,
        input  slv_ack, slv_err, slv_rdata
    );

    modport master (
        output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        input  reg_ack, reg_err, reg_rdata,
        input  slv_request, slv_write, slv_addr, slv_size, slv_wdata,
        output slv_ack, slv_err, slv_rdata
    );
endinterface

// File: rtl/peripheral_dbg_soc_osd_regaccess_router.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_soc_osd_regaccess_router
//
// Routes register requests from an OSD register-access layer to one of NSLV
// local register banks selected by address window, waits for that bank's
// ack/err (optionally bounded by TIMEOUT cycles) and answers the requester
// with a one-cycle reg_ack (with read data) or reg_err. Unmapped addresses,
// oversized accesses and timeouts all end in reg_err so the requester never
// stalls forever.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   busy : high whenever the router is not idle
//   bus  : reg_* / slv_* bundle, router side (slave modport)
// ---------------------------------------------------------------------------
module peripheral_dbg_soc_osd_regaccess_router #(
    parameter int                  NSLV         = 2,
    parameter int                  MAX_REG_SIZE = 16,
    parameter logic [NSLV*16-1:0]  SLV_BASE     = 32'h0400_0200,
    parameter logic [NSLV*16-1:0]  SLV_MASK     = 32'hFF00_FF00,
    parameter int                  TIMEOUT      = 64
) (
    input  logic clk,
    input  logic rst,
    output logic busy,
    peripheral_dbg_soc_osd_regaccess_router_if.slave bus
);

    localparam int SELW     = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNTW_RAW = $clog2(TIMEOUT + 1);
    localparam int CNTW     = (CNTW_RAW < 1) ? 1 : CNTW_RAW;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e                  state_q,       state_d;
    logic [SELW-1:0]         sel_q,         sel_d;
    logic [CNTW-1:0]         cnt_q,         cnt_d;
    logic [NSLV-1:0]         slv_request_q, slv_request_d;
    logic                    slv_write_q,   slv_write_d;
    logic [15:0]             slv_addr_q,    slv_addr_d;
    logic [1:0]              slv_size_q,    slv_size_d;
    logic [MAX_REG_SIZE-1:0] slv_wdata_q,   slv_wdata_d;
    logic [MAX_REG_SIZE-1:0] rdata_q,       rdata_d;

    logic                    hit_s;
    logic [SELW-1:0]         hit_idx_s;
    logic                    size_ok_s;
    logic                    sel_ack_s;
    logic                    sel_err_s;
    logic [MAX_REG_SIZE-1:0] sel_rdata_s;

    // Address window decode; scanning from the top down lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((bus.reg_addr & SLV_MASK[16*i +: 16]) == SLV_BASE[16*i +: 16]) begin
                hit_s     = 1'b1;
                hit_idx_s = SELW'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Access size check and selection of the active bank's response lines.
    always_comb begin
        size_ok_s   = ((32'd16 << bus.reg_size) <= 32'(MAX_REG_SIZE));
        sel_ack_s   = bus.slv_ack[sel_q];
        sel_err_s   = bus.slv_err[sel_q];
        sel_rdata_s = bus.slv_rdata[sel_q*MAX_REG_SIZE +: MAX_REG_SIZE];
    end

    // Next-state and datapath update for the request/response FSM.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        slv_request_d = slv_request_q;
        slv_write_d   = slv_write_q;
        slv_addr_d    = slv_addr_q;
        slv_size_d    = slv_size_q;
        slv_wdata_d   = slv_wdata_q;
        rdata_d       = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.reg_request) begin
                    if (!size_ok_s) begin
                        state_d = ST_ERR;
                    end else if (!hit_s) begin
                        state_d = ST_ERR;
                    end else begin
                        sel_d                    = hit_idx_s;
                        slv_request_d            = '0;
                        slv_request_d[hit_idx_s] = 1'b1;
                        slv_write_d              = bus.reg_write;
                        slv_addr_d               = bus.reg_addr;
                        slv_size_d               = bus.reg_size;
                        slv_wdata_d              = bus.reg_wdata;
                        cnt_d                    = '0;
                        state_d                  = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                // Error wins over a simultaneous ack from the same bank.
                if (sel_err_s) begin
                    slv_request_d = '0;
                    state_d       = ST_ERR;
                end else if (sel_ack_s) begin
                    slv_request_d = '0;
                    rdata_d       = sel_rdata_s;
                    state_d       = ST_ACK;
                // The edge that finds the counter at TIMEOUT gives up, which puts
                // reg_err TIMEOUT+1 cycles after slv_request rose.
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_MAX)) begin
                    slv_request_d = '0;
                    state_d       = ST_ERR;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                slv_request_d = '0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            slv_request_q <= '0;
            slv_write_q   <= 1'b0;
            slv_addr_q    <= 16'h0000;
            slv_size_q    <= 2'b00;
            slv_wdata_q   <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            slv_request_q <= slv_request_d;
            slv_write_q   <= slv_write_d;
            slv_addr_q    <= slv_addr_d;
            slv_size_q    <= slv_size_d;
            slv_wdata_q   <= slv_wdata_d;
            rdata_q       <= rdata_d;
        end
    end

    // Every output comes straight from a flop (state or datapath register).
    assign bus.reg_ack     = (state_q == ST_ACK);
    assign bus.reg_err     = (state_q == ST_ERR);
    assign bus.reg_rdata   = rdata_q;
    assign bus.slv_request = slv_request_q;
    assign bus.slv_write   = slv_write_q;
    assign bus.slv_addr    = slv_addr_q;
    assign bus.slv_size    = slv_size_q;
    assign bus.slv_wdata   = slv_wdata_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_regaccess_router.sv
// ---------------------------------------------------------------------------
// tb_peripheral_dbg_soc_osd_regaccess_router
//
// Table-driven bench: each vector issues one register request, a small bank
// model answers after a programmed delay, and the expected response (error
// flag, read data, arrival cycle) is queued on a scoreboard that a monitor
// pops whenever reg_ack or reg_err shows up. Hand-written sequences cover a
// late bank ack after a timeout and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_peripheral_dbg_soc_osd_regaccess_router;

    localparam int NSLV = 2;
    localparam int MRS  = 16;
    localparam int TO   = 64;

    logic clk;
    logic rst;
    logic busy;

    peripheral_dbg_soc_osd_regaccess_router_if #(.NSLV(NSLV), .MAX_REG_SIZE(MRS)) bus ();

    peripheral_dbg_soc_osd_regaccess_router #(
        .NSLV(NSLV), .MAX_REG_SIZE(MRS),
        .SLV_BASE(32'h0400_0200), .SLV_MASK(32'hFF00_FF00), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard entry: what the next reg_ack/reg_err must look like and when.
    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          at_cyc;
    } sb_t;
    sb_t sb_q[$];

    // Stimulus/expectation record. resp bit0 = bank ack, bit1 = bank err.
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [15:0] wdata;
        int          bank;
        logic [1:0]  resp;
        int          dly;
        int          decoy;
        logic [15:0] brdata;
        logic [1:0]  exp_req;
        logic        exp_err;
        int          lat;
    } vec_t;

    logic [15:0] model_rdata = 16'h0000;

    // Monitor: every requester response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.reg_ack || bus.reg_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {30'd0, bus.reg_err, bus.reg_ack}, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("resp_err",   32'(bus.reg_err), 32'(e.err));
                check("resp_ack",   32'(bus.reg_ack), 32'(!e.err));
                check("resp_rdata", 32'(bus.reg_rdata), 32'(e.rdata));
                check("resp_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        sb_t         e;
        bit          seen = 1'b0;
        bit          done = 1'b0;
        int          k = 0;
        logic [1:0]  req_seen = 2'b00;
        @(negedge clk);
        bus.reg_request = 1'b1;
        bus.reg_write   = v.wr;
        bus.reg_addr    = v.addr;
        bus.reg_size    = v.size;
        bus.reg_wdata   = v.wdata;
        e.err    = v.exp_err;
        e.rdata  = v.exp_err ? model_rdata : v.brdata;
        e.at_cyc = cyc + v.lat;
        if (!v.exp_err) model_rdata = v.brdata;
        sb_q.push_back(e);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            bus.slv_ack   = '0;
            bus.slv_err   = '0;
            bus.slv_rdata = '0;
            if (!seen && bus.slv_request != 2'b00) begin
                seen     = 1'b1;
                req_seen = bus.slv_request;
                check($sformatf("v%0d_slv_addr", idx),  32'(bus.slv_addr),  32'(v.addr));
                check($sformatf("v%0d_slv_wdata", idx), 32'(bus.slv_wdata), 32'(v.wdata));
                check($sformatf("v%0d_slv_write", idx), 32'(bus.slv_write), 32'(v.wr));
                check($sformatf("v%0d_slv_size", idx),  32'(bus.slv_size),  32'(v.size));
            end
            if (bus.reg_ack || bus.reg_err) begin
                done = 1'b1;
            end else if (seen) begin
                if (k == v.decoy) begin
                    bus.slv_ack[1 - v.bank] = 1'b1;
                    bus.slv_rdata[16*(1 - v.bank) +: 16] = 16'hDEAD;
                end
                if (k == v.dly) begin
                    bus.slv_ack[v.bank] = v.resp[0];
                    bus.slv_err[v.bank] = v.resp[1];
                    bus.slv_rdata[16*v.bank +: 16] = v.brdata;
                end
                k++;
            end
        end
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_slv_request", idx), 32'(req_seen), 32'(v.exp_req));
        check($sformatf("v%0d_req_dropped", idx), 32'(bus.slv_request), 32'd0);
        check($sformatf("v%0d_busy_resp", idx), 32'(busy), 32'd1);
        bus.reg_request = 1'b0;
        bus.slv_ack     = '0;
        bus.slv_err     = '0;
        @(negedge clk);
        check($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        // wr addr size wdata bank resp dly decoy brdata exp_req exp_err lat
        vecs[0] = '{1'b0, 16'h0210, 2'd0, 16'h0000, 0, 2'b01, 0, -1, 16'hBEEF, 2'b01, 1'b0, 2};
        vecs[1] = '{1'b1, 16'h0405, 2'd0, 16'h1234, 1, 2'b01, 5, -1, 16'hA5A5, 2'b10, 1'b0, 7};
        vecs[2] = '{1'b0, 16'h0800, 2'd0, 16'h0000, 0, 2'b01, 0, -1, 16'h1111, 2'b00, 1'b1, 1};
        vecs[3] = '{1'b0, 16'h0200, 2'd1, 16'h0000, 0, 2'b01, 0, -1, 16'h2222, 2'b00, 1'b1, 1};
        vecs[4] = '{1'b0, 16'h02FF, 2'd0, 16'h0000, 0, 2'b10, 2, -1, 16'h3333, 2'b01, 1'b1, 4};
        vecs[5] = '{1'b0, 16'h0201, 2'd0, 16'h0000, 0, 2'b11, 1, -1, 16'h4444, 2'b01, 1'b1, 3};
        vecs[6] = '{1'b0, 16'h04A0, 2'd0, 16'h0000, 1, 2'b01, 0, -1, 16'h1357, 2'b10, 1'b0, 2};
        vecs[7] = '{1'b0, 16'h0220, 2'd0, 16'h0000, 0, 2'b01, 3,  0, 16'h2468, 2'b01, 1'b0, 5};
        vecs[8] = '{1'b0, 16'h0400, 2'd3, 16'h0000, 1, 2'b01, 0, -1, 16'h5555, 2'b00, 1'b1, 1};
        vecs[9] = '{1'b0, 16'h0210, 2'd0, 16'h0000, 0, 2'b00, 0, -1, 16'h6666, 2'b01, 1'b1, TO + 2};

        rst             = 1'b1;
        bus.reg_request = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_addr    = 16'h0000;
        bus.reg_size    = 2'd0;
        bus.reg_wdata   = 16'h0000;
        bus.slv_ack     = '0;
        bus.slv_err     = '0;
        bus.slv_rdata   = '0;
        repeat (3) @(negedge clk);
        check("rst_reg_ack",     32'(bus.reg_ack),     32'd0);
        check("rst_reg_err",     32'(bus.reg_err),     32'd0);
        check("rst_busy",        32'(busy),            32'd0);
        check("rst_slv_request", 32'(bus.slv_request), 32'd0);
        check("rst_reg_rdata",   32'(bus.reg_rdata),   32'd0);
        check("rst_slv_addr",    32'(bus.slv_addr),    32'd0);
        check("rst_slv_wdata",   32'(bus.slv_wdata),   32'd0);
        check("rst_slv_write",   32'(bus.slv_write),   32'd0);
        check("rst_slv_size",    32'(bus.slv_size),    32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // A bank ack arriving after the timeout (router idle) must be ignored.
        bus.slv_ack[0] = 1'b1;
        bus.slv_rdata  = 32'h0000_7777;
        @(negedge clk);
        bus.slv_ack = '0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_ignored", {30'd0, bus.reg_err, bus.reg_ack}, 32'd0);
            check("late_ack_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of WAIT aborts the request without a response.
        bus.reg_request = 1'b1;
        bus.reg_write   = 1'b0;
        bus.reg_addr    = 16'h0210;
        bus.reg_size    = 2'd0;
        @(negedge clk);
        check("mid_rst_wait_req", 32'(bus.slv_request), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_slv_request", 32'(bus.slv_request), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        bus.reg_request = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 16'h0000;
        run_vec(vecs[0], 10);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute bound on the run in case something stalls outside the loops.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
